// File: rtl/demux16_tdm_pkg.sv
// Shared constants and helpers for the 16-slot TDM demultiplexer.
// FSM encoding, slot geometry and the frame bit-reversal helper.
package demux16_tdm_pkg;

  localparam int N_SLOTS = 16;
  localparam int SLOT_W  = 4;

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

  function automatic logic [N_SLOTS-1:0] bit_rev(
    input logic [N_SLOTS-1:0] v
  );
    logic [N_SLOTS-1:0] r;
    for (int i = 0; i < N_SLOTS; i++) begin
      r[i] = v[N_SLOTS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/demux16_tdm_if.sv
// Serial sample input and demultiplexed frame output bundle.
// master: din/din_valid/sync out, status in; slave: the reverse.
interface demux16_tdm_if;
  import demux16_tdm_pkg::*;

  logic               din;
  logic               din_valid;
  logic               sync;
  logic [N_SLOTS-1:0] q;
  logic               q_valid;
  logic [SLOT_W-1:0]  slot;
  logic               locked;
  logic               err;

  modport master (
    output din, din_valid, sync,
    input  q, q_valid, slot, locked, err
  );

  modport slave (
    input  din, din_valid, sync,
    output q, q_valid, slot, locked, err
  );

endinterface

// File: rtl/demux16_slot_ctr.sv
// Slot index counter: clear, load-to-1, increment (wraps 15->0).
// Ports: clk, rst_n, clr, load1, inc -> cnt.
module demux16_slot_ctr
  import demux16_tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SLOT_W'(1);
    end else if (inc) begin
      cnt <= cnt + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/demux16_tdm.sv
// 16-slot serial TDM demultiplexer with HUNT/COLLECT framing.
// Ports: clk, rst_n, bus (slave: din/din_valid/sync in; q/q_valid/slot/locked/err out).
module demux16_tdm
  import demux16_tdm_pkg::*;
#(
  parameter int REVERSE = 1
) (
  input logic          clk,
  input logic          rst_n,
  demux16_tdm_if.slave bus
);

  logic [0:0]         state;
  logic [0:0]         state_nx;
  logic [N_SLOTS-1:0] shadow;
  logic [N_SLOTS-1:0] shadow_nx;
  logic [N_SLOTS-1:0] frame;
  logic [N_SLOTS-1:0] q_r;
  logic               qv_r;
  logic               err_r;
  logic [SLOT_W-1:0]  slot_cnt;
  logic               ctr_clr;
  logic               ctr_ld1;
  logic               ctr_inc;
  logic               fire;
  logic               bad;
  logic               hunt;
  logic               slot0;

  assign hunt  = (state == HUNT);
  assign slot0 = (slot_cnt == '0);

  demux16_slot_ctr u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .load1 (ctr_ld1),
    .inc   (ctr_inc),
    .cnt   (slot_cnt)
  );

  // shadow[k] holds slot k; the last slot comes straight from din
  always_comb begin
    frame              = shadow;
    frame[N_SLOTS-1]   = bus.din;
  end

  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    ctr_clr   = 1'b0;
    ctr_ld1   = 1'b0;
    ctr_inc   = 1'b0;
    fire      = 1'b0;
    bad       = 1'b0;
    if (bus.din_valid) begin
      unique case (1'b1)
        hunt: begin
          if (bus.sync) begin
            shadow_nx = {{(N_SLOTS-1){1'b0}}, bus.din};
            ctr_ld1   = 1'b1;
            state_nx  = COLLECT;
          end
        end
        // sync restarts the frame; early sync is a framing error
        !hunt && bus.sync: begin
          bad       = !slot0;
          shadow_nx = {{(N_SLOTS-1){1'b0}}, bus.din};
          ctr_ld1   = 1'b1;
        end
        !hunt && !bus.sync && slot0: begin
          bad      = 1'b1;
          ctr_clr  = 1'b1;
          state_nx = HUNT;
        end
        !hunt && !bus.sync && !slot0: begin
          shadow_nx[slot_cnt] = bus.din;
          ctr_inc             = 1'b1;
          fire                = (slot_cnt == LAST_SLOT);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      shadow <= '0;
      q_r    <= '0;
      qv_r   <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      shadow <= shadow_nx;
      qv_r   <= fire;
      err_r  <= bad;
      if (fire) begin
        q_r <= (REVERSE != 0) ? bit_rev(frame) : frame;
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = qv_r;
  assign bus.slot    = slot_cnt;
  assign bus.locked  = (state == COLLECT);
  assign bus.err     = err_r;

endmodule
